pc_fetch_unit: RTL and testbench

- Upstream fetch stage of the MIPS datapath: owns the program-counter register and drives the 32-bit PC into the instruction memory each cycle.
- Computes the next PC for sequential, branch, jump and jump-register flow, and supplies the link values needed by jal/jalr.
- Holds off updates under stall, buffering a redirect that arrives while stalled.
- Traps illegal fetch targets (misaligned or outside the instruction-memory window) into a sticky fault state.

---
 rtl/pc_fetch_unit_pkg.sv | 31 +++
 rtl/pc_fetch_unit_npc_calc.sv | 53 +++++
 rtl/pc_fetch_unit.sv | 103 ++++++++++
 tb/tb_pc_fetch_unit.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the fetch stage: next-PC select codes, FSM states,
// the instruction-memory window base and the fetch-target legality check.
package pc_fetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam int unsigned IM_DEPTH_DEFAULT = 1024;

  typedef enum logic [1:0] {
    NPC_SEQ = 2'd0,
    NPC_BR  = 2'd1,
    NPC_J   = 2'd2,
    NPC_JR  = 2'd3
  } npc_sel_e;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HOLD  = 2'd1,
    FAULT = 2'd2
  } state_e;

  // Word aligned and inside [base, base + 4*depth); the limit is 33 bits so a
  // window touching the top of the address space does not wrap.
  function automatic logic target_legal(input logic [31:0]   addr,
                                        input logic [31:0]   base,
                                        input int unsigned   depth);
    logic [32:0] w_limit;
    w_limit = {1'b0, base} + (33'(depth) << 2);
    return (addr[1:0] == 2'b00) && (addr >= base) && ({1'b0, addr} < w_limit);
  endfunction

endpackage

// File: rtl/pc_fetch_unit_npc_calc.sv
// Combinational next-PC selection: target mux, redirect detect and legality
// of the selected target against the instruction-memory window.
module npc_calc
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned IM_DEPTH = IM_DEPTH_DEFAULT
) (
  input  logic [31:0] i_pc,
  input  logic [1:0]  i_npc_sel,
  input  logic        i_br_taken,
  input  logic [15:0] i_imm16,
  input  logic [25:0] i_addr26,
  input  logic [31:0] i_ra,
  output logic [31:0] o_target,
  output logic        o_redirect,
  output logic        o_legal
);

  logic [31:0] w_seq;
  logic [31:0] w_br;
  logic [31:0] w_j;

  assign w_seq = i_pc + 32'd4;
  assign w_br  = w_seq + {{14{i_imm16[15]}}, i_imm16, 2'b00};
  assign w_j   = {w_seq[31:28], i_addr26, 2'b00};

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    o_target   = w_seq;
    o_redirect = 1'b0;
    case (npc_sel_e'(i_npc_sel))
      NPC_SEQ: o_target = w_seq;
      NPC_BR: begin
        o_target   = i_br_taken ? w_br : w_seq;
        o_redirect = i_br_taken;
      end
      NPC_J: begin
        o_target   = w_j;
        o_redirect = 1'b1;
      end
      NPC_JR: begin
        o_target   = i_ra;
        o_redirect = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_legal = target_legal(o_target, RESET_PC, IM_DEPTH);

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch-stage PC register with stall handling, a one-entry redirect buffer
// used while stalled, and a sticky fault state for illegal fetch targets.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned IM_DEPTH = IM_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  npc_sel,
  input  logic        br_taken,
  input  logic [15:0] imm16,
  input  logic [25:0] addr26,
  input  logic [31:0] ra,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] pc_plus8,
  output logic        pending,
  output logic        fault
);

  state_e      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_pend_tgt;

  state_e      w_state_nxt;
  logic [31:0] w_pc_nxt;
  logic [31:0] w_pend_tgt_nxt;
  logic [31:0] w_target;
  logic        w_redirect;
  logic        w_target_legal;
  logic        w_pend_legal;

  npc_calc #(
    .RESET_PC (RESET_PC),
    .IM_DEPTH (IM_DEPTH)
  ) u_npc_calc (
    .i_pc       (r_pc),
    .i_npc_sel  (npc_sel),
    .i_br_taken (br_taken),
    .i_imm16    (imm16),
    .i_addr26   (addr26),
    .i_ra       (ra),
    .o_target   (w_target),
    .o_redirect (w_redirect),
    .o_legal    (w_target_legal)
  );

  // The buffered target is checked when it is released, not when captured.
  assign w_pend_legal = target_legal(r_pend_tgt, RESET_PC, IM_DEPTH);

  always_ff @(posedge clk) begin
    // NOTE: state registers use nonblocking assignments so every flop samples
    // the pre-edge values regardless of process ordering.
    if (!reset) begin
      r_state    <= RUN;
      r_pc       <= RESET_PC;
      r_pend_tgt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_pend_tgt <= w_pend_tgt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_pend_tgt_nxt = r_pend_tgt;
    case (r_state)
      RUN: begin
        if (!stall) begin
          if (w_target_legal) w_pc_nxt    = w_target;
          else                w_state_nxt = FAULT;
        end else if (w_redirect) begin
          w_pend_tgt_nxt = w_target;
          w_state_nxt    = HOLD;
        end
      end
      HOLD: begin
        if (stall) begin
          if (w_redirect) w_pend_tgt_nxt = w_target;
        end else if (w_pend_legal) begin
          w_pc_nxt    = r_pend_tgt;
          w_state_nxt = RUN;
        end else begin
          w_state_nxt = FAULT;
        end
      end
      FAULT:   ;
      default: w_state_nxt = FAULT;
    endcase
  end

  assign pc       = r_pc;
  assign pc_plus4 = r_pc + 32'd4;
  assign pc_plus8 = r_pc + 32'd8;
  assign pending  = (r_state == HOLD);
  assign fault    = (r_state == FAULT);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: a behavioural fetch model checked against
// the DUT every cycle, plus literal expectations at the key points.
module tb_pc_fetch_unit;

  localparam logic [31:0] BASE  = 32'h0000_3000;
  localparam logic [31:0] LIMIT = 32'h0000_4000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic [1:0]  npc_sel = 2'd0;
  logic        br_taken = 1'b0;
  logic [15:0] imm16 = 16'h0;
  logic [25:0] addr26 = 26'h0;
  logic [31:0] ra = 32'h0;
  logic [31:0] pc, pc_plus4, pc_plus8;
  logic        pending, fault;

  int total = 0;
  int bad   = 0;

  pc_fetch_unit dut (
    .clk      (clk),
    .reset    (reset),
    .stall    (stall),
    .npc_sel  (npc_sel),
    .br_taken (br_taken),
    .imm16    (imm16),
    .addr26   (addr26),
    .ra       (ra),
    .pc       (pc),
    .pc_plus4 (pc_plus4),
    .pc_plus8 (pc_plus8),
    .pending  (pending),
    .fault    (fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_valid = 0;
  logic [31:0] m_pc;
  bit          m_pend;
  logic [31:0] m_ptgt;
  bit          m_fault;

  function automatic bit legal(input logic [31:0] a);
    return (a % 4 == 0) && (a >= BASE) && (a < LIMIT);
  endfunction

  always @(posedge clk) begin
    logic [31:0] tgt;
    bit          redir;
    case (npc_sel)
      2'd0:    begin tgt = m_pc + 4; redir = 0; end
      2'd1:    begin
        tgt   = br_taken ? m_pc + 4 + 32'($signed(imm16)) * 4 : m_pc + 4;
        redir = br_taken;
      end
      2'd2:    begin tgt = ((m_pc + 4) & 32'hF000_0000) | (32'(addr26) * 4); redir = 1; end
      default: begin tgt = ra; redir = 1; end
    endcase
    if (!reset) begin
      m_valid = 1; m_pc = BASE; m_pend = 0; m_ptgt = 0; m_fault = 0;
    end else if (m_valid && !m_fault) begin
      if (m_pend) begin
        if (stall) begin
          if (redir) m_ptgt = tgt;
        end else begin
          m_pend = 0;
          if (legal(m_ptgt)) m_pc = m_ptgt;
          else               m_fault = 1;
        end
      end else if (stall) begin
        if (redir) begin m_ptgt = tgt; m_pend = 1; end
      end else if (legal(tgt)) m_pc = tgt;
      else                     m_fault = 1;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("pc",       pc,       m_pc);
      check("pc_plus4", pc_plus4, m_pc + 4);
      check("pc_plus8", pc_plus8, m_pc + 8);
      check("pending",  32'(pending), 32'(m_pend));
      check("fault",    32'(fault),   32'(m_fault));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic rst_v, input logic stall_v, input logic [1:0] sel,
                     input logic br_v, input logic [15:0] imm_v,
                     input logic [25:0] a26_v, input logic [31:0] ra_v);
    @(negedge clk);
    reset = rst_v; stall = stall_v; npc_sel = sel; br_taken = br_v;
    imm16 = imm_v; addr26 = a26_v; ra = ra_v;
    @(posedge clk);
    #1;
  endtask

  task automatic seq();
    cyc(1, 0, 2'd0, 0, 16'h0, 26'h0, 32'h0);
  endtask

  task automatic jr(input logic stall_v, input logic [31:0] tgt);
    cyc(1, stall_v, 2'd3, 0, 16'h0, 26'h0, tgt);
  endtask

  initial begin
    // 1. reset and sequential fetch
    cyc(0, 0, 2'd0, 0, 16'h0, 26'h0, 32'h0);
    check("reset_pc", pc, 32'h3000);
    check("reset_fault", 32'(fault), 32'd0);
    seq(); check("seq1", pc, 32'h3004);
    seq(); check("seq2", pc, 32'h3008);
    seq(); check("seq3", pc, 32'h300C);
    check("seq3_plus8", pc_plus8, 32'h3014);

    // 2. branch taken / not taken
    seq(); check("seq4", pc, 32'h3010);
    cyc(1, 0, 2'd1, 1, 16'hFFFC, 26'h0, 32'h0); check("br_taken", pc, 32'h3004);
    jr(0, 32'h3010);
    cyc(1, 0, 2'd1, 0, 16'hFFFC, 26'h0, 32'h0); check("br_not_taken", pc, 32'h3014);
    cyc(1, 0, 2'd1, 1, 16'h0003, 26'h0, 32'h0); check("br_fwd", pc, 32'h3024);

    // 3. jump and jump register
    jr(0, 32'h3000);
    cyc(1, 0, 2'd2, 0, 16'h0, 26'h0000C40, 32'h0); check("jump", pc, 32'h3100);
    jr(0, 32'h3008); check("jr", pc, 32'h3008);

    // 4. stall with redirect buffering
    cyc(1, 1, 2'd0, 0, 16'h0, 26'h0, 32'h0);
    check("stall_noredir_pc", pc, 32'h3008);
    check("stall_noredir_pend", 32'(pending), 32'd0);
    jr(1, 32'h3020);
    check("hold_pend", 32'(pending), 32'd1);
    check("hold_pc", pc, 32'h3008);
    jr(1, 32'h3040);
    cyc(1, 1, 2'd0, 0, 16'h0, 26'h0, 32'h0);
    check("hold_keep", pc, 32'h3008);
    seq();
    check("release_pc", pc, 32'h3040);
    check("release_pend", 32'(pending), 32'd0);

    // 5. misaligned target faults; inputs ignored; reset recovers
    jr(0, 32'h3002);
    check("misalign_fault", 32'(fault), 32'd1);
    check("misalign_pc", pc, 32'h3040);
    jr(0, 32'h3000);
    cyc(1, 1, 2'd2, 0, 16'h0, 26'h0000C40, 32'h0);
    check("fault_frozen", pc, 32'h3040);
    check("fault_sticky", 32'(fault), 32'd1);
    cyc(0, 0, 2'd0, 0, 16'h0, 26'h0, 32'h0);
    check("fault_reset_pc", pc, 32'h3000);
    check("fault_reset_flag", 32'(fault), 32'd0);

    // window edges via jump register
    jr(0, 32'h2FFC); check("below_window", 32'(fault), 32'd1);
    cyc(0, 0, 2'd0, 0, 16'h0, 26'h0, 32'h0);
    jr(0, 32'h4000); check("above_window", 32'(fault), 32'd1);
    cyc(0, 0, 2'd0, 0, 16'h0, 26'h0, 32'h0);
    jr(0, 32'h3FFC); check("top_word", pc, 32'h3FFC);

    // illegal pending target faults on release
    cyc(0, 0, 2'd0, 0, 16'h0, 26'h0, 32'h0);
    jr(1, 32'h5000);
    jr(0, 32'h3010);
    check("pend_illegal_fault", 32'(fault), 32'd1);
    check("pend_illegal_pc", pc, 32'h3000);

    // 6. sequential run to the last word, then fall off the window
    cyc(0, 0, 2'd0, 0, 16'h0, 26'h0, 32'h0);
    for (int i = 0; i < 1023; i++) seq();
    check("last_word", pc, 32'h3FFC);
    check("last_word_ok", 32'(fault), 32'd0);
    seq();
    check("seq_overrun_fault", 32'(fault), 32'd1);
    check("seq_overrun_pc", pc, 32'h3FFC);

    // reset in the middle of a HOLD
    cyc(0, 0, 2'd0, 0, 16'h0, 26'h0, 32'h0);
    seq();
    jr(1, 32'h3020);
    check("pre_reset_pend", 32'(pending), 32'd1);
    cyc(0, 1, 2'd3, 0, 16'h0, 26'h0, 32'h3020);
    check("hold_reset_pend", 32'(pending), 32'd0);
    check("hold_reset_pc", pc, 32'h3000);
    cyc(1, 0, 2'd0, 0, 16'h0, 26'h0, 32'h0);
    check("after_hold_reset", pc, 32'h3004);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
